fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the main control decoder.
- Holds the PC and fetches words from instruction memory over a ready-based handshake.
- Presents the instruction register, plus op/funct slices, to decode/execute.
- Computes the next PC from the decoder's jump/jr/jal outputs and the datapath's branch decision, and supplies pcplus4 for the JAL link write.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word-aligned).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset (asserted at 0).
imem_req  output  1  fetch request to instruction memory.
imem_addr  output  32  fetch address; equals pc.
imem_rdata  input  32  instruction word from memory.
imem_ready  input  1  imem_rdata valid this cycle; meaningful only while imem_req=1.
instr  output  32  instruction register.
op  output  6  instr[31:26].
funct  output  6  instr[5:0].
instr_valid  output  1  instr holds an unexecuted instruction.
instr_ready  input  1  downstream executes/accepts instr this cycle.
branch_taken  input  1  resolved branch condition for the accepted instruction (branch & (zero XOR bne)).
jump  input  1  J/JAL redirect.
jr  input  1  JR redirect.
rs_data  input  32  register rs value; JR target.
pc  output  32  address of the instruction in instr.
pcplus4  output  32  pc + 4, mod 2^32; JAL link value.
misalign_err  output  1  sticky flag: a JR target had nonzero low bits.
retired_count  output  32  count of accepted instructions.

Behaviour:
- States: BOOT, FETCH, HOLD.
- Reset (reset=0, asynchronous) forces:
  - state=BOOT, pc=RESET_PC, instr=0, instr_valid=0.
  - misalign_err=0, retired_count=0.
  - imem_req=0.
- Reset mid-fetch or mid-hold abandons the transaction. Memory must tolerate a request being dropped.
- BOOT: imem_req=0. Unconditionally goes to FETCH on the next edge. This gives one idle cycle after reset release.
- FETCH:
  - imem_req=1, imem_addr=pc, instr_valid=0.
  - imem_ready=0: stay in FETCH, holding the request and address stable.
  - imem_ready=1: instr <= imem_rdata, go to HOLD.
  - Minimum fetch latency is 1 cycle, so the instruction is visible the cycle after ready.
- HOLD:
  - imem_req=0, instr_valid=1. imem_ready is ignored.
  - instr_ready=0: stay in HOLD; instr, pc and pcplus4 stay stable.
  - instr_ready=1 (accept): pc <= next_pc, retired_count <= retired_count+1 (wraps at 2^32), go to FETCH.
  - Throughput is at most one instruction per 2 cycles.
- next_pc is evaluated only on accept. Priority, highest first:
  - jr: {rs_data[31:2],2'b00}. If rs_data[1:0]!=0, misalign_err <= 1 (sticky until reset).
  - jump: {pcplus4[31:28], instr[25:0], 2'b00}. JAL asserts jump, so it takes this path.
  - branch_taken: pcplus4 + (sign-extended instr[15:0] << 2), modulo 2^32.
  - otherwise: pcplus4.
- Simultaneous redirects resolve by the priority above; no error is flagged.
- pcplus4 is combinational from pc. At pc=32'hFFFF_FFFC it wraps to 0, and the branch adder wraps likewise.
- op/funct are combinational slices of instr. The decoder therefore sees stable values throughout HOLD.
- Redirect inputs and instr_ready are ignored outside HOLD. instr_ready with instr_valid=0 has no effect.
- pc[1:0] is always 00.

Test Plan:
- Reset with RESET_PC=0x100, release, imem_ready=1 constantly, memory returns ADD words -> imem_req low 1 cycle then high. Addresses 0x100, 0x104, 0x108. instr_valid alternates, retired_count increments per accept.
- imem_ready held low 3 cycles in FETCH -> imem_req=1 and imem_addr constant for 4 cycles. instr_valid=0 until the cycle after imem_ready=1.
- BEQ at pc=0x200, imm=0xFFFE, branch_taken=1 -> next imem_addr=0x1FC. Same with branch_taken=0 -> 0x204.
- JAL at pc=0x3000_0010, target field 0x0000040 -> pcplus4=0x3000_0014 during HOLD, next imem_addr=0x3000_0100. JR with rs_data=0x00000403 and jump=1 simultaneously -> addr 0x400, misalign_err=1 stays set.
- instr_ready low 5 cycles in HOLD while redirect inputs toggle -> pc and instr unchanged, no fetch. pc=0xFFFF_FFFC sequential accept -> next imem_addr=0.
- Assert reset during FETCH wait and during HOLD -> outputs return to reset values immediately (asynchronously). Fetch resumes at RESET_PC after the BOOT cycle.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a ready handshake, holds the
// instruction for decode and computes the redirect/sequential next PC on accept.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] rs_data,
    output logic [31:0] pc,
    output logic [31:0] pcplus4,
    output logic        misalign_err,
    output logic [31:0] retired_count
);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_misalign;
    logic [31:0] r_retired;

    logic [1:0]  w_state_next;
    logic        w_capture;
    logic        w_accept;
    logic [31:0] w_pcplus4;
    logic [31:0] w_br_off;
    logic [31:0] w_next_pc;

    assign w_capture = (r_state == ST_FETCH) && imem_ready;
    assign w_accept  = (r_state == ST_HOLD) && instr_ready;
    assign w_pcplus4 = r_pc + 32'd4;
    assign w_br_off  = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};

    // Redirect priority: jr over jump over branch over sequential.
    always_comb begin
        w_next_pc = w_pcplus4;
        if (jr) begin
            w_next_pc = {rs_data[31:2], 2'b00};
        end else if (jump) begin
            w_next_pc = {w_pcplus4[31:28], r_instr[25:0], 2'b00};
        end else if (branch_taken) begin
            w_next_pc = w_pcplus4 + w_br_off;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_BOOT:  w_state_next = ST_FETCH;
            ST_FETCH: if (imem_ready) w_state_next = ST_HOLD;
            ST_HOLD:  if (instr_ready) w_state_next = ST_FETCH;
            default:  w_state_next = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_PC;
            r_instr    <= 32'd0;
            r_misalign <= 1'b0;
            r_retired  <= 32'd0;
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_instr <= imem_rdata;
            end
            if (w_accept) begin
                r_pc      <= w_next_pc;
                r_retired <= r_retired + 32'd1;
                if (jr && (rs_data[1:0] != 2'b00)) begin
                    r_misalign <= 1'b1;
                end
            end
        end
    end

    assign imem_req      = (r_state == ST_FETCH);
    assign imem_addr     = r_pc;
    assign instr         = r_instr;
    assign op            = r_instr[31:26];
    assign funct         = r_instr[5:0];
    assign instr_valid   = (r_state == ST_HOLD);
    assign pc            = r_pc;
    assign pcplus4       = w_pcplus4;
    assign misalign_err  = r_misalign;
    assign retired_count = r_retired;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected fetch addresses and accept
// records; a negedge monitor pops and compares whenever the DUT fetches or retires.
module tb_fetch_unit;

    localparam logic [31:0] W_ADD = 32'h012A_4020;
    localparam logic [31:0] W_SUB = 32'h014B_4822;
    localparam logic [31:0] W_J   = 32'h0800_0080;
    localparam logic [31:0] W_BEQ = 32'h1109_FFFE;
    localparam logic [31:0] W_JR  = 32'h0100_0008;
    localparam logic [31:0] W_JAL = 32'h0C00_0040;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pcp4;
        logic [31:0] instr;
        logic [31:0] cnt;
    } acc_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_taken;
    logic        jump;
    logic        jr;
    logic [31:0] rs_data;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic        misalign_err;
    logic [31:0] retired_count;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_retired = 32'd0;
    logic [31:0] q_addr[$];
    acc_t        q_acc[$];
    logic [31:0] m_addr;
    acc_t        m_acc;

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_ready   (imem_ready),
        .instr        (instr),
        .op           (op),
        .funct        (funct),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .branch_taken (branch_taken),
        .jump         (jump),
        .jr           (jr),
        .rs_data      (rs_data),
        .pc           (pc),
        .pcplus4      (pcplus4),
        .misalign_err (misalign_err),
        .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_pc"}, pc, 32'h0000_0100);
        chk({tag, "_addr"}, imem_addr, 32'h0000_0100);
        chk({tag, "_instr"}, instr, 32'd0);
        chk({tag, "_retired"}, retired_count, 32'd0);
        chk({tag, "_misalign"}, {31'd0, misalign_err}, 32'd0);
    endtask

    task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] word,
                            input int delay);
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (imem_req !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL fetch_wait: imem_req=%b expected 1 within 20 cycles", imem_req);
            return;
        end
        q_addr.push_back(exp_addr);
        for (int i = 0; i < delay; i++) begin
            tick();
            chk("stall_req", {31'd0, imem_req}, 32'd1);
            chk("stall_addr", imem_addr, exp_addr);
            chk("stall_valid", {31'd0, instr_valid}, 32'd0);
        end
        imem_rdata = word;
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        imem_rdata = 32'd0;
        chk("valid_after_ready", {31'd0, instr_valid}, 32'd1);
    endtask

    task automatic do_accept(input logic [31:0] exp_pc, input logic [31:0] exp_instr,
                             input int hold, input logic t_jr, input logic t_jump,
                             input logic t_br, input logic [31:0] t_rs);
        for (int i = 0; i < hold; i++) begin
            jump         = i[0];
            jr           = i[1];
            branch_taken = ~i[0];
            rs_data      = 32'hDEAD_BEE1;
            tick();
            chk("hold_pc", pc, exp_pc);
            chk("hold_instr", instr, exp_instr);
            chk("hold_req", {31'd0, imem_req}, 32'd0);
            chk("hold_valid", {31'd0, instr_valid}, 32'd1);
        end
        q_acc.push_back('{exp_pc, exp_pc + 32'd4, exp_instr, exp_retired});
        exp_retired  = exp_retired + 32'd1;
        instr_ready  = 1'b1;
        jr           = t_jr;
        jump         = t_jump;
        branch_taken = t_br;
        rs_data      = t_rs;
        tick();
        instr_ready  = 1'b0;
        jr           = 1'b0;
        jump         = 1'b0;
        branch_taken = 1'b0;
        rs_data      = 32'd0;
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && imem_req === 1'b1 && imem_ready === 1'b1) begin
            if (q_addr.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL fetch_unexpected: addr %h expected no fetch", imem_addr);
            end else begin
                m_addr = q_addr.pop_front();
                chk("fetch_addr", imem_addr, m_addr);
            end
        end
        if (reset === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
            if (q_acc.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL accept_unexpected: pc %h expected no accept", pc);
            end else begin
                m_acc = q_acc.pop_front();
                chk("acc_pc", pc, m_acc.pc);
                chk("acc_pcplus4", pcplus4, m_acc.pcp4);
                chk("acc_instr", instr, m_acc.instr);
                chk("acc_op", {26'd0, op}, {26'd0, m_acc.instr[31:26]});
                chk("acc_funct", {26'd0, funct}, {26'd0, m_acc.instr[5:0]});
                chk("acc_retired", retired_count, m_acc.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b0;
        imem_rdata   = 32'd0;
        imem_ready   = 1'b0;
        instr_ready  = 1'b0;
        branch_taken = 1'b0;
        jump         = 1'b0;
        jr           = 1'b0;
        rs_data      = 32'd0;
        tick();
        tick();
        chk_reset_state("reset");

        reset = 1'b1;
        chk("boot_req", {31'd0, imem_req}, 32'd0);
        tick();
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0000_0100);

        do_fetch(32'h0000_0100, W_ADD, 0);
        do_accept(32'h0000_0100, W_ADD, 0, 1'b0, 1'b0, 1'b0, 32'd0);
        do_fetch(32'h0000_0104, W_ADD, 0);
        do_accept(32'h0000_0104, W_ADD, 0, 1'b0, 1'b0, 1'b0, 32'd0);
        do_fetch(32'h0000_0108, W_ADD, 3);
        do_accept(32'h0000_0108, W_ADD, 0, 1'b0, 1'b0, 1'b0, 32'd0);

        do_fetch(32'h0000_010C, W_J, 0);
        do_accept(32'h0000_010C, W_J, 0, 1'b0, 1'b1, 1'b0, 32'd0);
        do_fetch(32'h0000_0200, W_BEQ, 0);
        do_accept(32'h0000_0200, W_BEQ, 0, 1'b0, 1'b0, 1'b1, 32'd0);
        do_fetch(32'h0000_01FC, W_J, 0);
        do_accept(32'h0000_01FC, W_J, 0, 1'b0, 1'b1, 1'b0, 32'd0);
        do_fetch(32'h0000_0200, W_BEQ, 0);
        do_accept(32'h0000_0200, W_BEQ, 0, 1'b0, 1'b0, 1'b0, 32'd0);

        do_fetch(32'h0000_0204, W_JR, 0);
        do_accept(32'h0000_0204, W_JR, 0, 1'b1, 1'b0, 1'b0, 32'h3000_0010);
        chk("aligned_jr_no_err", {31'd0, misalign_err}, 32'd0);
        do_fetch(32'h3000_0010, W_JAL, 0);
        chk("jal_pcplus4", pcplus4, 32'h3000_0014);
        do_accept(32'h3000_0010, W_JAL, 0, 1'b0, 1'b1, 1'b0, 32'd0);
        do_fetch(32'h3000_0100, W_JR, 0);
        do_accept(32'h3000_0100, W_JR, 0, 1'b1, 1'b1, 1'b0, 32'h0000_0403);
        chk("misalign_set", {31'd0, misalign_err}, 32'd1);

        do_fetch(32'h0000_0400, W_ADD, 0);
        do_accept(32'h0000_0400, W_ADD, 5, 1'b0, 1'b0, 1'b0, 32'd0);
        do_fetch(32'h0000_0404, W_JR, 0);
        do_accept(32'h0000_0404, W_JR, 0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC);
        do_fetch(32'hFFFF_FFFC, W_ADD, 0);
        chk("wrap_pcplus4", pcplus4, 32'd0);
        do_accept(32'hFFFF_FFFC, W_ADD, 0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("misalign_sticky", {31'd0, misalign_err}, 32'd1);
        chk("wrap_req", {31'd0, imem_req}, 32'd1);
        chk("wrap_addr", imem_addr, 32'd0);
        chk("retired_before_reset", retired_count, exp_retired);

        // Abandon the pending fetch at address 0 with a mid-cycle reset.
        tick();
        #2 reset = 1'b0;
        #1 chk_reset_state("rst_fetch");
        exp_retired = 32'd0;
        tick();
        reset = 1'b1;
        chk("reboot_req", {31'd0, imem_req}, 32'd0);
        tick();
        chk("refetch_addr", imem_addr, 32'h0000_0100);
        do_fetch(32'h0000_0100, W_SUB, 0);
        chk("hold_before_reset", instr, W_SUB);

        #2 reset = 1'b0;
        #1 chk_reset_state("rst_hold");
        tick();
        reset = 1'b1;
        tick();
        do_fetch(32'h0000_0100, W_ADD, 0);
        do_accept(32'h0000_0100, W_ADD, 0, 1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        chk("retired_after_reset", retired_count, 32'd1);
        chk("pc_after_reset", pc, 32'h0000_0104);

        chk("addr_queue_empty", q_addr.size(), 32'd0);
        chk("acc_queue_empty", q_acc.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
